seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 4..2^20.
REQ-002 The block SHALL have parameter GUARD, default 16, meaning anode-off cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have ports d0..d7, input, 4 each, digit values with d0 the rightmost digit.
REQ-006 The block SHALL have port en, input, 1, display enable.
REQ-007 The block SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-008 The block SHALL have port dp_mask, input, 8, decimal point request per digit; bit i maps to digit i.
REQ-009 The block SHALL have port an, output, 8, active-low anode select; bit i drives digit i.
REQ-010 The block SHALL have port seg, output, 7, active-low cathodes with seg[0]=a through seg[6]=g.
REQ-011 The block SHALL have port dp, output, 1, active-low decimal point.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL be asserted when count = SCAN_DIV-1.
REQ-013 The digit index idx (3 bits) SHALL increment on tick and wrap 7->0.
REQ-014 Frame snapshot: in every cycle with count=0 and idx=0, shadow registers SHALL load d0..d7, blank_lz and dp_mask; no other cycle loads them. This applies to the first cycle after reset release.
REQ-015 All displayed data SHALL come from the shadow registers only, so input changes mid-frame never tear the display.
REQ-016 Leading-zero blanking: when shadow blank_lz=1, digit i (i=7..1) SHALL be blanked if digit i and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-017 A blanked digit SHALL drive seg=7'h7F and dp=1; dp_mask SHALL NOT unblank it.
REQ-018 Hex decode, given as active-low {g..a}, 0-F, SHALL be: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-019 an, seg and dp SHALL be registered and SHALL reflect the (count, idx, shadow) state of the previous cycle, giving one cycle of latency.
REQ-020 Guard: while count < GUARD, an SHALL be 8'hFF; otherwise an SHALL be all ones except bit idx = 0.
REQ-021 With GUARD=0, the selected anode SHALL be active for the entire slot.
REQ-022 en=0 SHALL force an=8'hFF, seg=7'h7F and dp=1 on the next cycle; the prescaler, idx and snapshot SHALL keep running.
REQ-023 When en rises, output SHALL resume on the next cycle at the current idx with no restart.
REQ-024 dp SHALL be 0 when the selected digit is not blanked, shadow dp_mask[idx]=1 and the digit is outside guard; otherwise dp SHALL be 1.

Reset
REQ-025 While rst_n=0: count=0, idx=0, shadow digits=0, shadow blank_lz=0, shadow dp_mask=0, an=8'hFF, seg=7'h7F, dp=1.
REQ-026 rst_n assertion mid-slot SHALL take effect immediately, without waiting for a clock edge.
REQ-027 After release, scanning SHALL restart at idx 0 with a fresh snapshot.

Structure
REQ-028 Shared package seg7_pkg SHALL hold NUM_DIGITS=8, the 16-entry segment table and the SEG_OFF=7'h7F constant.
REQ-029 Sub-module seg7_decode SHALL be purely combinational, mapping a 4-bit value to 7-bit active-low segments; there SHALL be one instance, fed by the mux output.

Verification
REQ-030 The bench SHALL run with SCAN_DIV=8 and GUARD=2.
REQ-031 Scenario: d7..d0=1,2,3,4,5,6,7,8, en=1, blank_lz=0 -> an cycles FE,FD,...,7F with 6 active cycles per slot, and seg on digit 0 = 00 (value 8), on digit 7 = 79 (value 1).
REQ-032 Scenario: all digits 0 except d0=5, blank_lz=1 -> digits 7..1 give seg=7F; digit 0 gives seg=12; dp=1 throughout.
REQ-033 Scenario: digits 0,0,0,0,0,0x00A,0,3 (d2=A), blank_lz=1 -> d7..d3 blank; d2=08; d1=40 (inner zero not blanked); d0=30.
REQ-034 Scenario: change d0 from 1 to 2 while idx=3 -> digit 0 shows 79 for the rest of the frame and 24 from the next frame.
REQ-035 Scenario: dp_mask=8'h04 -> dp=0 only during the active part of the digit-2 slot; en=0 for 20 cycles -> an=FF, seg=7F, and idx keeps advancing.
REQ-036 Scenario: rst_n pulsed low mid-slot at idx=5 -> outputs go to reset values within the same cycle, then scanning resumes at idx 0 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: digit count,
// active-low hex segment table ({g..a}) and the all-segments-off pattern.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry [v] holds the active-low pattern for hex value v.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex-to-seven-segment decoder, active-low {g..a}.
// Purely combinational; no backpressure.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[val_i];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit seven-segment driver with frame snapshot,
// leading-zero blanking, anode guard band; outputs registered, 1 cycle latency.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    input  logic [3:0] d7,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [7:0] dp_mask,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] LAST_C = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          tick;
    logic          snap;
    logic          in_guard;

    logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
    logic                       blank_lz_q, blank_lz_d;
    logic [NUM_DIGITS-1:0]      dp_mask_q, dp_mask_d;

    logic [NUM_DIGITS-1:0] zero_run;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [3:0]            sel_val;
    logic                  sel_blank;
    logic [6:0]            sel_seg;

    logic [7:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    assign tick = (count_q == LAST_C);
    assign snap = (count_q == '0) && (idx_q == '0);

    if (GUARD == 0) begin : g_noguard
        assign in_guard = 1'b0;
    end else begin : g_guard
        localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
        assign in_guard = (count_q < GUARD_C);
    end

    always_comb begin
        count_d    = tick ? '0 : count_q + 1'b1;
        idx_d      = tick ? idx_q + 1'b1 : idx_q;
        dig_d      = dig_q;
        blank_lz_d = blank_lz_q;
        dp_mask_d  = dp_mask_q;
        if (snap) begin
            dig_d      = {d7, d6, d5, d4, d3, d2, d1, d0};
            blank_lz_d = blank_lz;
            dp_mask_d  = dp_mask;
        end
    end

    // zero_run[i] is set when digit i and every digit above it is zero.
    always_comb begin
        zero_run = '0;
        zero_run[NUM_DIGITS-1] = (dig_q[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_run[i] = zero_run[i+1] && (dig_q[i] == 4'd0);
        end
        blank_vec    = blank_lz_q ? zero_run : '0;
        blank_vec[0] = 1'b0;
    end

    assign sel_val   = dig_q[idx_q];
    assign sel_blank = blank_vec[idx_q];

    seg7_decode u_decode (
        .val_i (sel_val),
        .seg_o (sel_seg)
    );

    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (en) begin
            if (!in_guard) begin
                an_d[idx_q] = 1'b0;
            end
            if (!sel_blank) begin
                seg_d = sel_seg;
                dp_d  = !(dp_mask_q[idx_q] && !in_guard);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            idx_q      <= '0;
            dig_q      <= '0;
            blank_lz_q <= 1'b0;
            dp_mask_q  <= '0;
            an_q       <= 8'hFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            count_q    <= count_d;
            idx_q      <= idx_d;
            dig_q      <= dig_d;
            blank_lz_q <= blank_lz_d;
            dp_mask_q  <= dp_mask_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=8, GUARD=2; per-cycle expected
// values come from hand-written per-digit segment tables and the slot position.
module tb_seg7_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       en;
    logic       blank_lz;
    logic [7:0] dp_mask;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec;
    int n_err;
    int e;

    seg7_scan #(
        .SCAN_DIV (8),
        .GUARD    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .d6       (d6),
        .d7       (d7),
        .en       (en),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_digits(input logic [7:0][3:0] v);
        {d7, d6, d5, d4, d3, d2, d1, d0} = v;
    endtask

    // segs[i]: expected seg for digit i; dpv[i]: digit i should light dp when active.
    task automatic run_cycles(input int n, input logic [7:0][6:0] segs,
                              input logic [7:0] dpv, input string tag);
        int p, c, s;
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            p  = e - 1;
            c  = p % 8;
            s  = (p / 8) % 8;
            ea = 8'hFF;
            es = 7'h7F;
            ed = 1'b1;
            if (en) begin
                if (c >= 2) ea = ~(8'h01 << s);
                es = segs[s];
                ed = !(dpv[s] && (c >= 2));
            end
            check_eq($sformatf("%s_an_p%0d", tag, p), 32'(an), 32'(ea));
            if ((p % 64) != 0) check_eq($sformatf("%s_seg_p%0d", tag, p), 32'(seg), 32'(es));
            check_eq($sformatf("%s_dp_p%0d", tag, p), 32'(dp), 32'(ed));
        end
    endtask

    localparam logic [7:0][6:0] S31  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [7:0][6:0] S32  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12};
    localparam logic [7:0][6:0] S33  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h30};
    localparam logic [7:0][6:0] S34A = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h79};
    localparam logic [7:0][6:0] S34B = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h24};

    initial begin
        n_vec    = 0;
        n_err    = 0;
        e        = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        blank_lz = 1'b0;
        dp_mask  = 8'h00;
        set_digits({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});

        repeat (2) @(negedge clk);
        check_eq("rst_an", 32'(an), 32'h0FF);
        check_eq("rst_seg", 32'(seg), 32'h07F);
        check_eq("rst_dp", 32'(dp), 32'h1);

        // Plain scan of 1..8; snapshot taken on the first edge after release.
        rst_n = 1'b1;
        run_cycles(64, S31, 8'h00, "scan");

        // Only d0 nonzero with blanking; dp request on blanked digit 7 stays dark.
        set_digits({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5});
        blank_lz = 1'b1;
        dp_mask  = 8'h80;
        run_cycles(64, S32, 8'h00, "lz5");

        // Inner zero below a nonzero digit stays visible.
        set_digits({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hA, 4'd0, 4'd3});
        dp_mask = 8'h00;
        run_cycles(64, S33, 8'h00, "lzA");

        // Mid-frame change of d0 at idx 3 must wait for the next frame.
        blank_lz = 1'b0;
        set_digits({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1});
        run_cycles(25, S34A, 8'h00, "tear_a");
        d0 = 4'd2;
        run_cycles(39, S34A, 8'h00, "tear_b");
        run_cycles(64, S34B, 8'h00, "tear_c");

        // Decimal point on digit 2, then a 20-cycle disable window.
        set_digits({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});
        dp_mask = 8'h04;
        run_cycles(10, S31, 8'h04, "dp");
        en = 1'b0;
        run_cycles(20, S31, 8'h04, "dis");
        en = 1'b1;
        run_cycles(34, S31, 8'h04, "resume");

        // Asynchronous reset mid-slot at idx 5, away from any clock edge.
        run_cycles(44, S31, 8'h04, "pre_rst");
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_an", 32'(an), 32'h0FF);
        check_eq("arst_seg", 32'(seg), 32'h07F);
        check_eq("arst_dp", 32'(dp), 32'h1);
        set_digits({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5});
        blank_lz = 1'b1;
        dp_mask  = 8'h80;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e     = 0;
        run_cycles(64, S32, 8'h00, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
